// File: rtl/acc_resp_responder.sv
// Reference accelerator endpoint: decodes q-channel ALU requests, runs them through a
// Latency-deep pipeline and returns in-order p-channel responses. Optional ACC_RESP_RESPONDER_STATS_EN adds counters.
module acc_resp_responder #(
  parameter int DataWidth = 32,
  parameter int AddrWidth = 4,
  parameter int IdWidth   = 1,
  parameter int AccAddr   = 0,
  parameter int Latency   = 2,
  parameter int Depth     = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [AddrWidth-1:0]         q_addr_i,
  input  logic [IdWidth-1:0]           q_id_i,
  input  logic [31:0]                  q_instr_data_i,
  input  logic [DataWidth-1:0]         q_rs1_i,
  input  logic [DataWidth-1:0]         q_rs2_i,
  input  logic [DataWidth-1:0]         q_rs3_i,
  input  logic                         q_valid_i,
  output logic                         q_ready_o,
  output logic [DataWidth-1:0]         p_data_o,
  output logic [IdWidth-1:0]           p_id_o,
  output logic                         p_error_o,
  output logic                         p_valid_o,
  input  logic                         p_ready_i,
  output logic                         busy_o,
  output logic [$clog2(Depth+1)-1:0]   outstanding_o
`ifdef ACC_RESP_RESPONDER_STATS_EN
  ,
  input  logic                         stat_clr_i,
  output logic [31:0]                  stat_req_o,
  output logic [31:0]                  stat_err_o
`endif
);

  localparam int CntW = $clog2(Depth+1);
  localparam int ShW  = $clog2(DataWidth);
  localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam logic [CntW-1:0]      DepthC   = CntW'(Depth);
  localparam logic [AddrWidth-1:0] AccAddrC = AddrWidth'(AccAddr);
  localparam logic [PtrW-1:0]      PtrLast  = PtrW'(Depth-1);

  logic [2:0]           w_op;
  logic [4:0]           w_rd;
  logic                 w_err;
  logic                 w_resp;
  logic                 w_acc;
  logic [DataWidth-1:0] w_res;
  logic                 w_unused;

  logic [CntW-1:0]      r_outstanding;

  // r_pv: request occupies stage; r_pr: request produces a response
  logic [Latency-1:0]   r_pv;
  logic [Latency-1:0]   r_pr;
  logic [DataWidth-1:0] r_pd [Latency];
  logic [IdWidth-1:0]   r_pid [Latency];
  logic                 r_pe [Latency];

  logic [DataWidth-1:0] r_fd [Depth];
  logic [IdWidth-1:0]   r_fid [Depth];
  logic                 r_fe [Depth];
  logic [PtrW-1:0]      r_wr;
  logic [PtrW-1:0]      r_rd;
  logic [CntW-1:0]      r_fcnt;

  logic w_tail_v;
  logic w_fempty;
  logic w_pvalid;
  logic w_push;
  logic w_fpop;
  logic w_pdone;

  assign w_op     = q_instr_data_i[14:12];
  assign w_rd     = q_instr_data_i[11:7];
  assign w_unused = ^{q_instr_data_i[31:15], q_instr_data_i[6:0]};
  assign w_err    = (w_op == 3'd7) || (q_addr_i != AccAddrC);
  assign w_resp   = (w_rd != 5'd0) || w_err;
  assign q_ready_o = (r_outstanding < DepthC);
  assign w_acc    = q_valid_i && q_ready_o;

  always_comb begin
    w_res = '0;
    case (w_op)
      3'd0: w_res = q_rs1_i + q_rs2_i;
      3'd1: w_res = q_rs1_i - q_rs2_i;
      3'd2: w_res = q_rs1_i & q_rs2_i;
      3'd3: w_res = q_rs1_i | q_rs2_i;
      3'd4: w_res = q_rs1_i ^ q_rs2_i;
      3'd5: w_res = q_rs1_i << q_rs2_i[ShW-1:0];
      3'd6: w_res = q_rs1_i + q_rs2_i + q_rs3_i;
      default: w_res = '0;
    endcase
    if (w_err) w_res = '0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_pv <= '0;
      r_pr <= '0;
      for (int k = 0; k < Latency; k++) begin
        r_pd[k]  <= '0;
        r_pid[k] <= '0;
        r_pe[k]  <= 1'b0;
      end
    end else begin
      r_pv[0]  <= w_acc;
      r_pr[0]  <= w_acc && w_resp;
      r_pd[0]  <= w_res;
      r_pid[0] <= q_id_i;
      r_pe[0]  <= w_err;
      for (int k = 1; k < Latency; k++) begin
        r_pv[k]  <= r_pv[k-1];
        r_pr[k]  <= r_pr[k-1];
        r_pd[k]  <= r_pd[k-1];
        r_pid[k] <= r_pid[k-1];
        r_pe[k]  <= r_pe[k-1];
      end
    end
  end

  // Pipeline tail bypasses the buffer when it is empty, so the response is
  // visible in the same cycle the result leaves the last stage.
  assign w_tail_v = r_pv[Latency-1] && r_pr[Latency-1];
  assign w_fempty = (r_fcnt == '0);
  assign w_pvalid = !w_fempty || w_tail_v;
  assign w_pdone  = w_pvalid && p_ready_i;
  assign w_fpop   = !w_fempty && p_ready_i;
  assign w_push   = w_tail_v && !(w_fempty && p_ready_i);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr   <= '0;
      r_rd   <= '0;
      r_fcnt <= '0;
      for (int k = 0; k < Depth; k++) begin
        r_fd[k]  <= '0;
        r_fid[k] <= '0;
        r_fe[k]  <= 1'b0;
      end
    end else begin
      if (w_push) begin
        r_fd[r_wr]  <= r_pd[Latency-1];
        r_fid[r_wr] <= r_pid[Latency-1];
        r_fe[r_wr]  <= r_pe[Latency-1];
        r_wr        <= (r_wr == PtrLast) ? '0 : r_wr + 1'b1;
      end
      if (w_fpop) r_rd <= (r_rd == PtrLast) ? '0 : r_rd + 1'b1;
      case ({w_push, w_fpop})
        2'b10:   r_fcnt <= r_fcnt + 1'b1;
        2'b01:   r_fcnt <= r_fcnt - 1'b1;
        default: r_fcnt <= r_fcnt;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_outstanding <= '0;
    end else begin
      case ({w_acc && w_resp, w_pdone})
        2'b10:   r_outstanding <= r_outstanding + 1'b1;
        2'b01:   r_outstanding <= r_outstanding - 1'b1;
        default: r_outstanding <= r_outstanding;
      endcase
    end
  end

  assign p_valid_o     = w_pvalid;
  assign p_data_o      = !w_pvalid ? '0 : (w_fempty ? r_pd[Latency-1]  : r_fd[r_rd]);
  assign p_id_o        = !w_pvalid ? '0 : (w_fempty ? r_pid[Latency-1] : r_fid[r_rd]);
  assign p_error_o     = !w_pvalid ? 1'b0 : (w_fempty ? r_pe[Latency-1] : r_fe[r_rd]);
  assign outstanding_o = r_outstanding;
  assign busy_o        = (r_outstanding != '0) || (|(r_pv & ~r_pr));

`ifdef ACC_RESP_RESPONDER_STATS_EN
  logic [31:0] r_stat_req;
  logic [31:0] r_stat_err;

  always_ff @(posedge clk_i) begin
    if (rst_i || stat_clr_i) begin
      r_stat_req <= '0;
      r_stat_err <= '0;
    end else begin
      if (w_acc)          r_stat_req <= r_stat_req + 32'd1;
      if (w_acc && w_err) r_stat_err <= r_stat_err + 32'd1;
    end
  end

  assign stat_req_o = r_stat_req;
  assign stat_err_o = r_stat_err;
`endif

endmodule
